// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartTx enqueue port among NREQ requesters.
// Round-robin at message granularity, optional per-message header byte
// (HDR_BASE | id), optional forced release after MAX_LEN data bytes.
module uart_tx_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         IDW      = 2,
  parameter bit         HDR_EN   = 1'b1,
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         MAX_LEN  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   io_req_valid,
  input  logic [8*NREQ-1:0] io_req_bits,
  input  logic [NREQ-1:0]   io_req_last,
  output logic [NREQ-1:0]   io_req_ready,
  output logic              io_tx_valid,
  output logic [7:0]        io_tx_bits,
  input  logic              io_tx_ready,
  output logic              io_busy,
  output logic [IDW-1:0]    io_grant_id,
  output logic              io_overrun
);

  localparam int LENW = (MAX_LEN > 0) ? $clog2(MAX_LEN + 1) : 1;
  localparam logic [LENW-1:0] LEN_LIM = LENW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  grant, grant_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [IDW-1:0]  pick, idx, grant_nxt;
  logic [LENW-1:0] len, len_d, len_inc;
  logic            overrun, overrun_d;
  logic            found;
  logic [7:0]      req_byte [NREQ];

  assign grant_nxt   = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign len_inc     = len + 1'b1;
  assign io_busy     = (state != IDLE);
  assign io_grant_id = grant;
  assign io_overrun  = overrun;

  // Unpack the flat byte bus into one byte per requester
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_byte[i] = io_req_bits[8*i +: 8];
    end
  end

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (!found && io_req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state, register updates and the pass-through datapath
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    ptr_d        = ptr;
    len_d        = len;
    overrun_d    = 1'b0;
    io_tx_valid  = 1'b0;
    io_tx_bits   = '0;
    io_req_ready = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          len_d   = '0;
          state_d = HDR_EN ? HDR : DATA;
        end
      end
      HDR: begin
        io_tx_valid = 1'b1;
        io_tx_bits  = HDR_BASE | 8'(grant);
        if (io_tx_ready) state_d = DATA;
      end
      DATA: begin
        io_tx_valid         = io_req_valid[grant];
        io_tx_bits          = req_byte[grant];
        io_req_ready[grant] = io_tx_ready;
        if (io_req_valid[grant] && io_tx_ready) begin
          len_d = len_inc;
          // last takes priority over the length limit: no overrun if both hit
          if (io_req_last[grant]) begin
            ptr_d   = grant_nxt;
            state_d = IDLE;
          end else if (MAX_LEN != 0 && len_inc == LEN_LIM) begin
            ptr_d     = grant_nxt;
            state_d   = IDLE;
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      len     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      ptr     <= ptr_d;
      len     <= len_d;
      overrun <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a
// message-level model predicts the enqueue stream, a monitor compares it.
module tb_uart_tx_arbiter;

  localparam int         NREQ     = 4;
  localparam int         IDW      = 2;
  localparam bit         HDR_EN   = 1'b1;
  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam int         MAX_LEN  = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NREQ-1:0]   io_req_valid;
  logic [8*NREQ-1:0] io_req_bits;
  logic [NREQ-1:0]   io_req_last;
  logic [NREQ-1:0]   io_req_ready;
  logic              io_tx_valid;
  logic [7:0]        io_tx_bits;
  logic              io_tx_ready;
  logic              io_busy;
  logic [IDW-1:0]    io_grant_id;
  logic              io_overrun;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .HDR_EN(HDR_EN), .HDR_BASE(HDR_BASE), .MAX_LEN(MAX_LEN)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .io_req_valid(io_req_valid), .io_req_bits(io_req_bits), .io_req_last(io_req_last),
    .io_req_ready(io_req_ready),
    .io_tx_valid(io_tx_valid), .io_tx_bits(io_tx_bits), .io_tx_ready(io_tx_ready),
    .io_busy(io_busy), .io_grant_id(io_grant_id), .io_overrun(io_overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]      b;
    int              id;
    logic [NREQ-1:0] rdy;
  } exp_t;

  exp_t       expq[$];
  logic [8:0] rq [NREQ][$];   // bytes still to be offered by each requester {last, byte}
  logic [8:0] mq [NREQ][$];   // model copy of the staged messages
  int k [NREQ];               // bytes accepted so far in the current message
  int hold [NREQ];            // forced stall cycles
  int m_ptr = 0, exp_ovr = 0, ovr_seen = 0, ovr_base = 0, n_xfer = 0;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp_v);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += rq[i].size();
    return s;
  endfunction

  // Monitor: every accepted enqueue must match the head of the expected queue
  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RESET) begin
      if (io_overrun) ovr_seen++;
      if (io_tx_valid && io_tx_ready) begin
        n_xfer++;
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_xfer: got 0x%0h, required no transfer", io_tx_bits);
        end else begin
          e = expq.pop_front();
          chk("tx_bits", io_tx_bits, e.b);
          chk("grant_id", io_grant_id, e.id);
          chk("req_ready", io_req_ready, e.rdy);
        end
      end
    end
  end

  // Requester side: retire bytes the DUT accepts
  always @(negedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NREQ; i++) begin
        if (io_req_valid[i] && io_req_ready[i] && rq[i].size() > 0) begin
          if (rq[i][0][8]) k[i] = 0;
          else k[i]++;
          void'(rq[i].pop_front());
        end
      end
    end
  end

  // Requester and UartTx drivers. A requester may drop valid only mid-segment,
  // so arbitration order depends only on which queues hold data.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          io_req_bits[8*i +: 8] = rq[i][0][7:0];
          io_req_last[i]        = rq[i][0][8];
          if (hold[i] > 0) begin
            io_req_valid[i] = 1'b0;
            hold[i]--;
          end else if (k[i] > 0 && (k[i] % MAX_LEN) != 0) begin
            io_req_valid[i] = ($urandom_range(0, 3) != 0);
          end else begin
            io_req_valid[i] = 1'b1;
          end
        end else begin
          io_req_valid[i]       = 1'b0;
          io_req_bits[8*i +: 8] = 8'($urandom);
          io_req_last[i]        = 1'($urandom);
        end
      end
      io_tx_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Message-level reference: round robin over non-empty queues from m_ptr
  task automatic model_run();
    int   sel, n;
    bit   found;
    logic [8:0] v;
    exp_t e;
    exp_ovr = 0;
    forever begin
      found = 1'b0;
      sel   = 0;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && mq[(m_ptr + j) % NREQ].size() > 0) begin
          found = 1'b1;
          sel   = (m_ptr + j) % NREQ;
        end
      end
      if (!found) break;
      if (HDR_EN) begin
        e.b = HDR_BASE | 8'(sel); e.id = sel; e.rdy = '0;
        expq.push_back(e);
      end
      n = 0;
      forever begin
        v = mq[sel].pop_front();
        e.b = v[7:0]; e.id = sel; e.rdy = NREQ'(1) << sel;
        expq.push_back(e);
        n++;
        if (v[8]) break;
        if (MAX_LEN != 0 && n == MAX_LEN) begin
          exp_ovr++;
          break;
        end
      end
      m_ptr = (sel + 1) % NREQ;
    end
    ovr_base = ovr_seen;
  endtask

  task automatic begin_phase();
    @(negedge CLK);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit last);
    rq[r].push_back({last, b});
    mq[r].push_back({last, b});
  endtask

  task automatic finish_phase(input string nm);
    int t = 0;
    while ((expq.size() != 0 || pending() != 0) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk({nm, "_drain"}, expq.size(), 0);
    repeat (3) @(negedge CLK);
    chk({nm, "_busy_idle"}, io_busy, 0);
    chk({nm, "_overruns"}, ovr_seen - ovr_base, exp_ovr);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_tx_valid"}, io_tx_valid, 0);
    chk({nm, "_req_ready"}, io_req_ready, 0);
    chk({nm, "_busy"}, io_busy, 0);
    chk({nm, "_grant_id"}, io_grant_id, 0);
    chk({nm, "_overrun"}, io_overrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int t, base, nm, ln;
    bit any;
    io_req_valid = '0;
    io_req_bits  = '0;
    io_req_last  = '0;
    io_tx_ready  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k[i] = 0;
      hold[i] = 0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_zero_outputs("reset");
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Contention from ptr=0: 0,1,3 each send one byte
    begin_phase();
    push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(3, 8'h13, 1'b1);
    model_run();
    finish_phase("contention");

    // Single requester, two-byte message
    begin_phase();
    push(2, 8'h55, 1'b0); push(2, 8'h5A, 1'b1);
    model_run();
    finish_phase("single");

    // Six bytes from req0: forced release after four, then a fresh header
    begin_phase();
    for (int j = 0; j < 6; j++) push(0, 8'(8'hC0 + j), j == 5);
    model_run();
    finish_phase("overrun");

    // Owner req1 stalls mid-message while req0 waits
    begin_phase();
    push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
    push(0, 8'h30, 1'b1);
    model_run();
    t = 0;
    while (k[1] == 0 && t < 500) begin
      @(negedge CLK);
      #2;
      t++;
    end
    chk("stall_started", k[1] > 0, 1);
    hold[1] = 50;
    repeat (3) @(negedge CLK);
    repeat (40) begin
      @(negedge CLK);
      chk("stall_tx_valid", io_tx_valid, 0);
      chk("stall_grant", io_grant_id, 1);
      chk("stall_ready0", io_req_ready[0], 0);
      chk("stall_busy", io_busy, 1);
    end
    finish_phase("stall");

    // Last byte coincides with the length limit: normal release
    begin_phase();
    for (int j = 0; j < MAX_LEN; j++) push(3, 8'(8'h60 + j), j == MAX_LEN - 1);
    model_run();
    finish_phase("last_at_limit");

    // Reset after header plus one data byte
    begin_phase();
    for (int j = 0; j < 4; j++) push(2, 8'(8'h40 + j), j == 3);
    model_run();
    base = n_xfer;
    t = 0;
    while (n_xfer - base < 2 && t < 500) begin
      @(negedge CLK);
      #2;
      t++;
    end
    chk("rst_progress", n_xfer - base, 2);
    @(posedge CLK);
    #1 RESET = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      mq[i].delete();
      k[i] = 0;
      hold[i] = 0;
    end
    expq.delete();
    m_ptr = 0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk_zero_outputs("midreset");

    // Clean re-grant after reset: ptr is back to 0
    begin_phase();
    push(3, 8'h53, 1'b1); push(1, 8'h51, 1'b1);
    model_run();
    finish_phase("post_reset");

    // Randomized phases
    for (int p = 0; p < 30; p++) begin
      begin_phase();
      any = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) != 0) begin
          any = 1'b1;
          nm = $urandom_range(1, 2);
          for (int m = 0; m < nm; m++) begin
            ln = $urandom_range(1, 9);
            for (int j = 0; j < ln; j++) push(r, 8'($urandom), j == ln - 1);
          end
        end
      end
      if (!any) push($urandom_range(0, NREQ - 1), 8'($urandom), 1'b1);
      model_run();
      finish_phase("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UartTx byte-enqueue port among NREQ requesters. Arbitration is round-robin at message granularity: a grant is held until the owner's byte marked last is accepted. Each message can be prefixed with a header byte that identifies the requester. The block sits between client logic and UartTx; io_tx_* connects directly to UartTx io_enq_*.

Parameters:
NREQ, 4, number of requesters (2..2^IDW)
IDW, 2, width of requester id
HDR_EN, 1, 1 = emit header byte (HDR_BASE | id) before each message
HDR_BASE, 8'hA0, header base value; low IDW bits must be 0
MAX_LEN, 16, max data bytes per message before forced release; 0 = unlimited

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
io_req_valid  in  NREQ  per-requester byte valid
io_req_bits  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
io_req_last  in  NREQ  byte is the last byte of its message
io_req_ready  out  NREQ  byte accepted this cycle when valid & ready
io_tx_valid  out  1  to UartTx io_enq_valid
io_tx_bits  out  8  to UartTx io_enq_bits
io_tx_ready  in  1  from UartTx io_enq_ready
io_busy  out  1  state != IDLE
io_grant_id  out  IDW  registered id of the current/last owner
io_overrun  out  1  one-cycle pulse on a MAX_LEN forced release

Behaviour:
- Registers: state {IDLE, HDR, DATA}, grant (IDW), ptr (IDW), len counter (enough bits for MAX_LEN), overrun (1).
- Reset values: state=IDLE, grant=0, ptr=0, len=0, overrun=0. Outputs in reset: io_tx_valid=0, io_req_ready=0, io_busy=0, io_grant_id=0, io_overrun=0.
- IDLE: io_tx_valid=0 and all io_req_ready=0.
  - If any io_req_valid is set, choose the first set index at or after ptr, wrapping modulo NREQ.
  - Load grant, clear len, and go to HDR (HDR_EN=1) or DATA (HDR_EN=0).
  - Arbitration latency is 1 cycle; nothing is transferred in the IDLE cycle.
- HDR: io_tx_valid=1, io_tx_bits=HDR_BASE|grant, all io_req_ready=0. When io_tx_ready=1, go to DATA.
- DATA, datapath:
  - io_tx_valid = io_req_valid[grant].
  - io_tx_bits = io_req_bits[grant].
  - io_req_ready[grant] = io_tx_ready; every other io_req_ready = 0.
- DATA, on handshake (io_req_valid[grant] & io_tx_ready):
  - len increments.
  - If io_req_last[grant]=1: ptr = (grant+1) mod NREQ, go to IDLE.
  - Else if MAX_LEN!=0 and len+1==MAX_LEN: same release, and io_overrun pulses on the next cycle.
- Grant stickiness: the owner may drop valid mid-message. The grant is held indefinitely; other requesters wait. There is no timeout.
- The ready/valid paths are combinational pass-through. UartTx ready is registered, so no combinational loop exists.
- io_req_ready must never depend on io_req_valid of a non-owner.
- Releases always pass through one IDLE cycle, so back-to-back messages have a 1-cycle gap at the enqueue interface. The gap is invisible on txd because UartTx is busy for the full frame.
- ptr advances only on release. A single active requester is re-granted repeatedly.
- Reset mid-message: returns to IDLE immediately with ptr=0. Partially sent bytes are not replayed. UartTx is reset by the same RESET.
- Simultaneous last and MAX_LEN on the same byte: counts as a normal last; no overrun pulse.
- Requests arriving while busy are ignored until the next IDLE cycle.

Test Plan:
- Single requester, HDR_EN=1: req2 sends 0x55, then 0x5A (last). Expected: UartTx accepts 0xA2, 0x55, 0x5A in order; txd shows three 10-bit frames; io_busy returns to 0; ptr=3.
- Contention: req0, req1 and req3 all valid with 1-byte messages (0x10, 0x11, 0x13, each last) from ptr=0. Expected enqueue order: A0,10,A1,11,A3,13; req1 and req3 ready=0 while req0 owns the port.
- Stall and hold: owner req1 drops valid for 50 cycles mid-message while req0 is valid. Expected: io_tx_valid=0, grant stays 1, req0 ready stays 0; the message resumes and completes.
- Overrun: MAX_LEN=4, req0 streams 6 bytes with no last. Expected: the 4th accepted byte releases the grant, io_overrun pulses once, and req0 is re-granted with a new header.
- Reset mid-message: assert RESET for 1 cycle after the header plus 1 data byte. Expected: all outputs are 0 the next cycle, state=IDLE, ptr=0, and a new request is granted cleanly.
- HDR_EN=0: two requesters each send 1 byte. Expected: only data bytes are enqueued, each grant has a 1-cycle IDLE gap, and grants alternate.
